multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Main controller for the multicycle RV32I core: Moore FSM sequencing fetch, decode, execute,
//  memory and writeback over one shared ALU and one shared instruction/data memory port.
//  Drives ImmSrc to the immediate sign extender and every datapath mux/enable; stalls on mem_ready.
//  Sits between the instruction register (op/funct fields) and the datapath.
// PARAMETERS
//  none; opcodes, encodings and state type live in ctrl_pkg.
// PORTS
//  clk         in   1  core clock, all state on rising edge
//  rst         in   1  synchronous, active-high reset
//  op          in   7  Instr[6:0] from the instruction register
//  funct3      in   3  Instr[14:12]
//  funct7b5    in   1  Instr[30]
//  zero        in   1  ALU zero flag
//  mem_ready   in   1  memory completes the current access this cycle
//  PCWrite     out  1  PC register enable
//  AdrSrc      out  1  memory address: 0=PC, 1=Result
//  MemWrite    out  1  memory write strobe
//  IRWrite     out  1  instruction register / OldPC enable
//  ResultSrc   out  2  00=ALUOut, 01=Data, 10=ALUResult
//  ALUSrcA     out  2  00=PC, 01=OldPC, 10=RD1
//  ALUSrcB     out  2  00=RD2, 01=ImmExt, 10=const 4
//  ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  ImmSrc      out  2  00 I, 01 S, 10 B, 11 J
//  RegWrite    out  1  register file write enable
//  illegal     out  1  sticky: unsupported opcode decoded
// BEHAVIOUR
//  - Reset: state=FETCH, illegal=0; while rst=1 PCWrite, MemWrite, IRWrite, RegWrite forced 0.
//    Unlisted mux outputs are 0.
//  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. Holds until mem_ready;
//    IRWrite=PCWrite=1 only in the mem_ready cycle, then -> DECODE.
//  - DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jump target into ALUOut); ImmSrc from op.
//    lw/sw->MEMADR, R->EXECUTER, I-ALU->EXECUTEI, branch->BRANCH, jal->JAL; other op->TRAP.
//  - MEMADR: SrcA=10, SrcB=01, add; ImmSrc=00(lw)/01(sw). lw->MEMREAD, sw->MEMWRITE.
//  - MEMREAD: ResultSrc=00, AdrSrc=1; holds until mem_ready, then -> MEMWB.
//  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
//  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 every cycle until mem_ready, then -> FETCH.
//  - EXECUTER: SrcA=10, SrcB=00, ALU decode -> ALUWB. EXECUTEI: SrcB=01, ImmSrc=00 -> ALUWB.
//  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
//  - BRANCH: SrcA=10, SrcB=00, sub, ResultSrc=00, ImmSrc=10; PCWrite=zero (beq, f3=000)
//    or !zero (bne, f3=001); other funct3 -> TRAP. -> FETCH.
//  - JAL: SrcA=01, SrcB=10, add, ResultSrc=00, PCWrite=1, ImmSrc=11 -> ALUWB.
//  - TRAP: all enables 0, illegal=1, stays until rst.
//  - ALU decode: lw/sw/jal add; branch sub; f3 000 add (sub if R and funct7b5), 010 slt,
//    110 or, 111 and; other funct3 -> TRAP.
//  - Cycle counts at mem_ready=1: R/I 4, lw 5, sw 4, branch 3, jal 4; each mem_ready=0 cycle
//    in FETCH/MEMREAD/MEMWRITE adds exactly one cycle, no output toggles while stalled.
//  - rst mid-instruction (any state, incl. stall) -> FETCH next edge; no partial write issued.
// CONFIGURATION
//  - JALR_EN defined: op 1100111 (f3=000) DECODE->JALR (SrcA=10, SrcB=01, add, ImmSrc=00)
//    ->JALRPC (ResultSrc=00, PCWrite=1, SrcA=01, SrcB=10, add) ->ALUWB; 5 cycles.
//  - JALR_EN undefined: op 1100111 -> TRAP like any unsupported opcode.
// STRUCTURE
//  - ctrl_pkg: state_t enum, opcode localparams, ImmSrc/ALUControl/mux-select localparams.
//  - Sub-module alu_decoder: combinational (ALUOp, funct3, funct7b5, op[5]) -> ALUControl, bad_f3.
// TESTING
//  - add x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH,DECODE,EXECUTER,ALUWB; RegWrite on 4th cycle, ALUControl=000.
//  - lw (0x0040A183) with mem_ready=0 for 2 cycles in MEMREAD -> 7 cycles, RegWrite once, ResultSrc=01.
//  - sw (0x0020A223) -> MemWrite held high until mem_ready, ImmSrc=01 in MEMADR, 4 cycles.
//  - beq zero=1 -> PCWrite=1 in BRANCH; bne zero=1 -> PCWrite=0; both 3 cycles, ImmSrc=10.
//  - jalr (0x000080E7) -> 5 cycles with JALR_EN, illegal=1 and no enables without; rst clears.
//  - rst asserted in MEMWRITE with mem_ready=0 -> MemWrite=0 that cycle, state FETCH next.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// immediate formats, ALU operations and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALRPC,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Immediate format selected in DECODE so the branch/jump target can be formed early.
  function automatic logic [1:0] immSrcFor(input logic [6:0] op);
    case (op)
      OP_STORE:  immSrcFor = IMM_S;
      OP_BRANCH: immSrcFor = IMM_B;
      OP_JAL:    immSrcFor = IMM_J;
      default:   immSrcFor = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp and the instruction function fields
// to an ALUControl code, flagging funct3 values the core does not implement.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] aluOp_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       opb5_i,
  output logic [2:0] aluControl_o,
  output logic       badF3_o
);

  always_comb begin
    aluControl_o = ALU_ADD;
    badF3_o      = 1'b0;
    case (aluOp_i)
      ALUOP_SUB: aluControl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // funct7b5 only selects sub for register-register ops; addi ignores it
          3'b000:  aluControl_o = (opb5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  aluControl_o = ALU_SLT;
          3'b110:  aluControl_o = ALU_OR;
          3'b111:  aluControl_o = ALU_AND;
          default: badF3_o = 1'b1;
        endcase
      end
      default: aluControl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main Moore controller of the multicycle RV32I core (shared ALU and memory port).
// Define JALR_EN to add jalr support; otherwise jalr traps like any unsupported opcode.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic       illegal_q;
  logic [1:0] aluOp;
  logic       badF3;

  alu_decoder u_aluDec (
    .aluOp_i      (aluOp),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .opb5_i       (op[5]),
    .aluControl_o (ALUControl),
    .badF3_o      (badF3)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
`ifdef JALR_EN
          OP_JALR:           state_d = (funct3 == 3'b000) ? S_JALR : S_TRAP;
`endif
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI: state_d = badF3 ? S_TRAP : S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? S_FETCH : S_TRAP;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALRPC;
      S_JALRPC:   state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  // illegal is raised on the edge that enters TRAP and only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == S_TRAP);
    end
  end

  assign illegal = illegal_q;

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ImmSrc    = IMM_I;
    aluOp     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = immSrcFor(op);
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        aluOp   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_I;
        aluOp   = ALUOP_FUNCT;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        aluOp   = ALUOP_SUB;
        ImmSrc  = IMM_B;
        PCWrite = (funct3 == 3'b000) ? zero : ((funct3 == 3'b001) ? ~zero : 1'b0);
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        ImmSrc  = IMM_J;
        PCWrite = 1'b1;
      end
      S_JALR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_I;
      end
      S_JALRPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      default: aluOp = ALUOP_ADD;
    endcase
    // Reset wins immediately so an interrupted access never issues a write
    if (rst) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule
